// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack unit:
//   - op_e        : command opcode encodings carried on cmd_op
//   - is_aligned  : byte address is a whole number of words
//   - word_addr_ok: aligned address of an existing word (READ/WRITE target)
//   - sp_addr_ok  : aligned address usable as a stack pointer (may equal TOP)
// Helpers take 64-bit operands so one copy serves any ADDR_W up to 64.
// ---------------------------------------------------------------------------
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POP    = 3'd2,
    OP_WRITE  = 3'd3,
    OP_READ   = 3'd4,
    OP_SET_SP = 3'd5
  } op_e;

  function automatic logic is_aligned(input logic [63:0] addr,
                                      input logic [63:0] wb);
    return (addr % wb) == 64'd0;
  endfunction

  function automatic logic word_addr_ok(input logic [63:0] addr,
                                        input logic [63:0] wb,
                                        input logic [63:0] top);
    return is_aligned(addr, wb) && (addr < top);
  endfunction

  // TOP itself is a legal stack pointer value: it means "empty".
  function automatic logic sp_addr_ok(input logic [63:0] addr,
                                      input logic [63:0] wb,
                                      input logic [63:0] top);
    return is_aligned(addr, wb) && (addr <= top);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// ---------------------------------------------------------------------------
// stack_ram
// DEPTH x DATA_W word memory, contents never reset.
// Ports:
//   clock            write clock
//   we/waddr/wdata   synchronous write port
//   raddr_a/rdata_a  asynchronous read port (stack-pointer word)
//   raddr_b/rdata_b  asynchronous read port (random-access word)
// Read ports are combinational so that a word written at one edge is
// visible to the very next command.
// ---------------------------------------------------------------------------
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
// Word-organised, downward-growing stack with an internal stack pointer,
// PUSH/POP, frame-relative READ/WRITE, SET_SP, sticky overflow/underflow
// flags and a one-entry valid/ready response register.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/cmd_addr/cmd_wdata command opcode, byte address, write data
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_err          response payload
//   sp, top                   stack pointer and word at sp (0 when empty)
//   overflow/underflow        sticky error flags, err_clear clears them
// sp == TOP means empty, sp == 0 means full.
// ---------------------------------------------------------------------------
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] sp,
  output logic [DATA_W-1:0] top,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clear
);

  localparam int WB    = DATA_W / 8;
  localparam int TOP   = DEPTH * WB;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] TOP_A  = ADDR_W'(TOP);
  localparam logic [ADDR_W-1:0] WB_A   = ADDR_W'(WB);
  localparam logic [63:0]       TOP_64 = 64'(TOP);
  localparam logic [63:0]       WB_64  = 64'(WB);

  logic [ADDR_W-1:0] sp_reg, sp_next;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              overflow_reg, underflow_reg;
  logic              ovf_set, unf_set;

  logic              accept;
  logic              full, empty;
  logic              word_ok, sp_ok;
  logic [IDX_W-1:0]  sp_idx, cmd_idx;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] sp_rdata, cmd_rdata;
  op_e               op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = !rsp_valid_reg || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (sp_reg == '0);
  assign empty     = (sp_reg == TOP_A);
  assign word_ok   = word_addr_ok(64'(cmd_addr), WB_64, TOP_64);
  assign sp_ok     = sp_addr_ok(64'(cmd_addr), WB_64, TOP_64);

  // When sp == TOP the index wraps to 0; that read is masked off below and
  // sp_idx - 1 then lands on the last word, which is where the first PUSH goes.
  assign sp_idx  = IDX_W'(sp_reg / WB_A);
  assign cmd_idx = IDX_W'(cmd_addr / WB_A);

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clock   (clock),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (cmd_wdata),
    .raddr_a (sp_idx),
    .rdata_a (sp_rdata),
    .raddr_b (cmd_idx),
    .rdata_b (cmd_rdata)
  );

  always_comb begin
    sp_next       = sp_reg;
    ram_we        = 1'b0;
    ram_waddr     = sp_idx - IDX_W'(1);
    rsp_data_next = '0;
    rsp_err_next  = 1'b0;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    if (accept) begin
      case (op)
        OP_NOP: begin
        end
        OP_PUSH: begin
          if (full) begin
            rsp_err_next = 1'b1;
            ovf_set      = 1'b1;
          end else begin
            sp_next = sp_reg - WB_A;
            ram_we  = 1'b1;
          end
        end
        OP_POP: begin
          if (empty) begin
            rsp_err_next = 1'b1;
            unf_set      = 1'b1;
          end else begin
            rsp_data_next = sp_rdata;
            sp_next       = sp_reg + WB_A;
          end
        end
        OP_WRITE: begin
          if (word_ok) begin
            ram_we    = 1'b1;
            ram_waddr = cmd_idx;
          end else begin
            rsp_err_next = 1'b1;
          end
        end
        OP_READ: begin
          if (word_ok) begin
            rsp_data_next = cmd_rdata;
          end else begin
            rsp_err_next = 1'b1;
          end
        end
        OP_SET_SP: begin
          if (sp_ok) begin
            sp_next = cmd_addr;
          end else begin
            rsp_err_next = 1'b1;
          end
        end
        default: begin
          rsp_err_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp_reg        <= TOP_A;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      sp_reg <= sp_next;
      if (accept) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= rsp_data_next;
        rsp_err_reg   <= rsp_err_next;
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
      // A new error event wins over a simultaneous clear.
      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (err_clear) begin
        overflow_reg <= 1'b0;
      end
      if (unf_set) begin
        underflow_reg <= 1'b1;
      end else if (err_clear) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign sp        = sp_reg;
  assign top       = empty ? '0 : sp_rdata;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
// Directed stimulus for stack_unit (DATA_W 32, DEPTH 128, ADDR_W 32).
// The driver queues the expected {err, data} of every command it issues; a
// monitor pops and compares each response as it is handed over.
// ---------------------------------------------------------------------------
module tb_stack_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] sp;
  logic [31:0] top;
  logic        overflow;
  logic        underflow;
  logic        err_clear;

  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          checks   = 0;
  int          failures = 0;
  int          rsp_n    = 0;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2,
                         WRITE = 3'd3, READ = 3'd4, SET_SP = 3'd5;

  always #5 clock = ~clock;

  stack_unit #(.DATA_W(32), .DEPTH(128), .ADDR_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sp        (sp),
    .top       (top),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clear (err_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command and return 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_d,
                      input logic exp_e);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    exp_q.push_back({exp_e, exp_d});
    forever begin
      @(negedge clock);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL cmd_accept_timeout: op %0d not accepted after %0d cycles", op, n);
        break;
      end
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Response monitor: one line per handed-over response.
  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      rsp_n++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got data 0x%08h err %0d, expected no response", rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rsp %0d: data=0x%08h err=%0d (expected 0x%08h err=%0d)",
                 rsp_n, rsp_data, rsp_err, mon_e[31:0], mon_e[32]);
        chk("rsp_data", rsp_data, mon_e[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e[32]});
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_addr  = 32'd0;
    cmd_wdata = 32'd0;
    rsp_ready = 1'b1;
    err_clear = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset_sp", sp, 32'h200);
    chk("reset_top", top, 32'h0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    @(posedge clock);
    #1;

    // Basic push/pop
    send(PUSH, 32'h0, 32'h11111111, 32'h0, 1'b0);
    chk("push1_sp", sp, 32'h1FC);
    chk("push1_top", top, 32'h11111111);
    send(PUSH, 32'h0, 32'h22222222, 32'h0, 1'b0);
    chk("push2_sp", sp, 32'h1F8);
    chk("push2_top", top, 32'h22222222);
    send(POP, 32'h0, 32'h0, 32'h22222222, 1'b0);
    chk("pop1_sp", sp, 32'h1FC);
    chk("pop1_top", top, 32'h11111111);
    send(POP, 32'h0, 32'h0, 32'h11111111, 1'b0);
    chk("pop2_sp", sp, 32'h200);
    chk("pop2_top", top, 32'h0);

    // NOP and illegal opcodes
    send(NOP, 32'h0, 32'h0, 32'h0, 1'b0);
    send(3'd6, 32'h0, 32'h0, 32'h0, 1'b1);
    send(3'd7, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("illegal_sp", sp, 32'h200);

    // Fill to full, overflow, clear
    for (int i = 0; i < 128; i++) begin
      send(PUSH, 32'h0, 32'h10000000 + 32'(i), 32'h0, 1'b0);
    end
    chk("full_sp", sp, 32'h0);
    chk("full_top", top, 32'h1000007F);
    send(READ, 32'h000, 32'h0, 32'h1000007F, 1'b0);
    send(READ, 32'h1FC, 32'h0, 32'h10000000, 1'b0);
    send(PUSH, 32'h0, 32'hBAD0BAD0, 32'h0, 1'b1);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_sp", sp, 32'h0);
    chk("ovf_top_kept", top, 32'h1000007F);
    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    send(POP, 32'h0, 32'h0, 32'h1000007F, 1'b0);
    chk("pop_full_sp", sp, 32'h4);

    // SET_SP bounds, then underflow
    send(SET_SP, 32'h201, 32'h0, 32'h0, 1'b1);
    send(SET_SP, 32'h204, 32'h0, 32'h0, 1'b1);
    chk("setsp_bad_sp", sp, 32'h4);
    send(SET_SP, 32'h200, 32'h0, 32'h0, 1'b0);
    chk("setsp_sp", sp, 32'h200);
    chk("setsp_top", top, 32'h0);
    send(POP, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("unf_flag", {31'd0, underflow}, 32'd1);
    chk("unf_sp", sp, 32'h200);

    // Random access, back-to-back write then read
    send(WRITE, 32'h1F0, 32'hDEADBEEF, 32'h0, 1'b0);
    send(READ, 32'h1F0, 32'h0, 32'hDEADBEEF, 1'b0);
    send(READ, 32'h1F2, 32'h0, 32'h0, 1'b1);
    send(READ, 32'h200, 32'h0, 32'h0, 1'b1);
    send(WRITE, 32'h1F2, 32'h12345678, 32'h0, 1'b1);
    send(WRITE, 32'h200, 32'h12345678, 32'h0, 1'b1);
    send(READ, 32'h1F0, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("rw_sp", sp, 32'h200);

    // Backpressure: response held, second command stalls
    send(PUSH, 32'h0, 32'h5A5A5A5A, 32'h0, 1'b0);
    rsp_ready = 1'b0;
    fork
      send(POP, 32'h0, 32'h0, 32'h5A5A5A5A, 1'b0);
      begin
        repeat (3) begin
          @(negedge clock);
          chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
          chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
          chk("stall_rsp_data", rsp_data, 32'h0);
          chk("stall_sp", sp, 32'h1FC);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
      end
    join
    chk("stall_pop_sp", sp, 32'h200);

    // Reset mid-stream with a pending response
    send(WRITE, 32'h100, 32'hCAFEF00D, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    send(PUSH, 32'h0, 32'h77777777, 32'h0, 1'b0);
    chk("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_reset_sp", sp, 32'h200);
    chk("mid_reset_top", top, 32'h0);
    chk("mid_reset_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("mid_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    send(READ, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0);
    send(READ, 32'h1FC, 32'h0, 32'h77777777, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
